// File: rtl/led_seq_pkg.sv
// Shared types for the LED bar sequencer: mode and auto-direction encodings.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_PAUSE  = 2'd2
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Auto-step prescaler: counts 0..TICK_DIV-1 while enabled, clear wins over enable.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 12_000_000,
    parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// One-hot LED bar sequencer with MANUAL / AUTO / PAUSE modes.
// Define LED_SEQ_BOUNCE_EN for ping-pong ends in AUTO instead of wrap.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TICK_DIV = 12_000_000,
    parameter int unsigned DIV_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_pulse,
    input  logic             down_pulse,
    input  logic             mode_pulse,
    output logic [WIDTH-1:0] led,
    output mode_e            mode,
    output logic             dir
);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("led_seq_ctrl: TICK_DIV must be >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("led_seq_ctrl: WIDTH must be >= 2");
    end

    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);

    logic [WIDTH-1:0] led_q, led_d;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    dir_e             step_dir;
    logic             tick;

    // Counter idles at zero in MANUAL, so entry into AUTO starts a full period.
    led_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mode_q == MODE_MANUAL),
        .en    (mode_q == MODE_AUTO),
        .tick  (tick)
    );

    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        dir_d    = dir_q;
        step_dir = dir_q;
        unique case (mode_q)
            MODE_MANUAL: begin
                if (mode_pulse) begin
                    mode_d = MODE_AUTO;
                    if (led_q == '0) led_d = LSB_ONE;
                end else if (up_pulse) begin
                    led_d = (led_q == '0) ? LSB_ONE : led_q << 1;
                end else if (down_pulse) begin
                    led_d = (led_q == '0) ? MSB_ONE : led_q >> 1;
                end
            end
            MODE_AUTO: begin
                if (mode_pulse) begin
                    mode_d = MODE_PAUSE;
                end else begin
                    if (up_pulse)        step_dir = DIR_UP;
                    else if (down_pulse) step_dir = DIR_DOWN;
                    dir_d = step_dir;
                    if (tick) begin
                        if (step_dir == DIR_UP) begin
                            if (led_q[WIDTH-1]) begin
`ifdef LED_SEQ_BOUNCE_EN
                                led_d = MSB_ONE >> 1;
                                dir_d = DIR_DOWN;
`else
                                led_d = LSB_ONE;
`endif
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
`ifdef LED_SEQ_BOUNCE_EN
                                led_d = LSB_ONE << 1;
                                dir_d = DIR_UP;
`else
                                led_d = MSB_ONE;
`endif
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                end
            end
            MODE_PAUSE: begin
                if (mode_pulse) mode_d = MODE_MANUAL;
            end
            default: begin
                mode_d = MODE_MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= '0;
            mode_q <= MODE_MANUAL;
            dir_q  <= DIR_UP;
        end else begin
            led_q  <= led_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign dir  = dir_q;

endmodule
